// File: rtl/branch_redirect_ctrl_if.sv
// Port bundle between branch_redirect_ctrl and its environment (EX-stage
// comparator on one side, fetch unit and IF/ID pipeline control on the other).
//   i_ex_valid      EX stage holds a valid instruction
//   i_br_en         branch/jump taken
//   i_br_target     computed target address
//   i_redir_ack     fetch unit accepts the redirect
//   o_redir_req     redirect request to fetch
//   o_redir_pc      redirect address, qualified by o_redir_req
//   o_flush         kill IF/ID instructions
//   o_stall         freeze the pipeline
//   o_misalign      one-cycle misaligned-target pulse
//   o_misalign_addr last misaligned target
//   o_taken_cnt     count of acknowledged redirects
// The master modport is the controller view, the slave modport the
// environment view.
interface branch_redirect_ctrl_if;
  logic        i_ex_valid;
  logic        i_br_en;
  logic [31:0] i_br_target;
  logic        i_redir_ack;
  logic        o_redir_req;
  logic [31:0] o_redir_pc;
  logic        o_flush;
  logic        o_stall;
  logic        o_misalign;
  logic [31:0] o_misalign_addr;
  logic [31:0] o_taken_cnt;

  modport master (
    input  i_ex_valid, i_br_en, i_br_target, i_redir_ack,
    output o_redir_req, o_redir_pc, o_flush, o_stall,
           o_misalign, o_misalign_addr, o_taken_cnt
  );

  modport slave (
    output i_ex_valid, i_br_en, i_br_target, i_redir_ack,
    input  o_redir_req, o_redir_pc, o_flush, o_stall,
           o_misalign, o_misalign_addr, o_taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer between the EX-stage branch comparator and the
// front end. A taken branch/jump in IDLE either raises a registered redirect
// request (aligned target) held until the fetch unit acknowledges, followed
// by FLUSH_CYCLES cycles of IF/ID kill, or, for a misaligned target, a
// one-cycle exception pulse with the offending address latched.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset; every output returns to 0
//   bus    branch_redirect_ctrl_if.master (see interface file for signals)
// Parameters:
//   FLUSH_CYCLES  flush cycles after acknowledge, 0..15
//   CNT_INIT      reset value of the redirect counter; left at 0 except to
//                 exercise counter rollover
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] CNT_INIT     = 32'h0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  branch_redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        redir_req_q, redir_req_d;
  // flush and stall are asserted in exactly the same cycles
  logic        hold_q, hold_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  logic trig;
  logic ack;

  assign trig = bus.i_ex_valid & bus.i_br_en;
  // an ack only counts while the request is actually on the bus
  assign ack  = bus.i_redir_ack & redir_req_q;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    redir_req_d     = 1'b0;
    hold_d          = 1'b0;
    redir_pc_d      = redir_pc_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    taken_cnt_d     = taken_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          if (bus.i_br_target[1:0] != 2'b00) begin
            misalign_d      = 1'b1;
            misalign_addr_d = bus.i_br_target;
          end else begin
            redir_pc_d  = bus.i_br_target;
            redir_req_d = 1'b1;
            hold_d      = 1'b1;
            state_d     = REQ;
          end
        end
      end

      REQ: begin
        if (ack) begin
          taken_cnt_d = taken_cnt_q + 32'd1;
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            fcnt_d  = FLUSH_LOAD;
            hold_d  = 1'b1;
            state_d = FLUSH;
          end
        end else begin
          redir_req_d = 1'b1;
          hold_d      = 1'b1;
        end
      end

      FLUSH: begin
        // the cycle with fcnt_q == 1 is the last flush cycle, so the
        // counter reaching 0 coincides with the return to IDLE
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) begin
          state_d = IDLE;
        end else begin
          hold_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= IDLE;
      fcnt_q          <= 4'd0;
      redir_req_q     <= 1'b0;
      hold_q          <= 1'b0;
      redir_pc_q      <= 32'h0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0;
      taken_cnt_q     <= CNT_INIT;
    end else begin
      state_q         <= state_d;
      fcnt_q          <= fcnt_d;
      redir_req_q     <= redir_req_d;
      hold_q          <= hold_d;
      redir_pc_q      <= redir_pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      taken_cnt_q     <= taken_cnt_d;
    end
  end

  assign bus.o_redir_req     = redir_req_q;
  assign bus.o_redir_pc      = redir_pc_q;
  assign bus.o_flush         = hold_q;
  assign bus.o_stall         = hold_q;
  assign bus.o_misalign      = misalign_q;
  assign bus.o_misalign_addr = misalign_addr_q;
  assign bus.o_taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl_if bi ();
  branch_redirect_ctrl_if bi0 ();

  branch_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bi.master)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_INIT(32'hFFFF_FFFE)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bi0.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bi.o_redir_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bi.o_redir_req); end
    total++; if (bi.o_flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b want 0", bi.o_flush); end
    total++; if (bi.o_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bi.o_stall); end
    total++; if (bi.o_redir_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", bi.o_redir_pc); end
    total++; if (bi.o_misalign !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", bi.o_misalign); end
    total++; if (bi.o_misalign_addr !== 32'h0) begin bad++; $display("FAIL rst_mis_addr: got %h want 0", bi.o_misalign_addr); end
    total++; if (bi.o_taken_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt: got %h want 0", bi.o_taken_cnt); end
    total++; if (bi0.o_taken_cnt !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rst_cnt0: got %h want fffffffe", bi0.o_taken_cnt); end
    rst = 1'b0;
    tick();
    total++; if (bi.o_redir_req !== 1'b0 || bi.o_flush !== 1'b0) begin bad++; $display("FAIL idle_after_rst: got req=%b flush=%b want 0 0", bi.o_redir_req, bi.o_flush); end
  endtask

  task automatic test_immediate_ack();
    bi.i_ex_valid = 1'b1; bi.i_br_en = 1'b1; bi.i_br_target = 32'h0000_1000;
    tick();
    bi.i_ex_valid = 1'b0; bi.i_br_en = 1'b0;
    total++; if (bi.o_redir_req !== 1'b1) begin bad++; $display("FAIL imm_req: got %b want 1", bi.o_redir_req); end
    total++; if (bi.o_flush !== 1'b1 || bi.o_stall !== 1'b1) begin bad++; $display("FAIL imm_hold1: got flush=%b stall=%b want 1 1", bi.o_flush, bi.o_stall); end
    total++; if (bi.o_redir_pc !== 32'h0000_1000) begin bad++; $display("FAIL imm_pc: got %h want 00001000", bi.o_redir_pc); end
    total++; if (bi.o_taken_cnt !== 32'd0) begin bad++; $display("FAIL imm_cnt_pre: got %0d want 0", bi.o_taken_cnt); end
    bi.i_redir_ack = 1'b1;
    tick();
    bi.i_redir_ack = 1'b0;
    total++; if (bi.o_redir_req !== 1'b0) begin bad++; $display("FAIL imm_req_drop: got %b want 0", bi.o_redir_req); end
    total++; if (bi.o_flush !== 1'b1 || bi.o_stall !== 1'b1) begin bad++; $display("FAIL imm_hold2: got flush=%b stall=%b want 1 1", bi.o_flush, bi.o_stall); end
    total++; if (bi.o_taken_cnt !== 32'd1) begin bad++; $display("FAIL imm_cnt: got %0d want 1", bi.o_taken_cnt); end
    tick();
    total++; if (bi.o_flush !== 1'b1 || bi.o_stall !== 1'b1) begin bad++; $display("FAIL imm_hold3: got flush=%b stall=%b want 1 1", bi.o_flush, bi.o_stall); end
    total++; if (bi.o_redir_req !== 1'b0) begin bad++; $display("FAIL imm_req_flush: got %b want 0", bi.o_redir_req); end
    tick();
    total++; if (bi.o_flush !== 1'b0 || bi.o_stall !== 1'b0) begin bad++; $display("FAIL imm_hold_end: got flush=%b stall=%b want 0 0", bi.o_flush, bi.o_stall); end
    total++; if (bi.o_redir_pc !== 32'h0000_1000) begin bad++; $display("FAIL imm_pc_keep: got %h want 00001000", bi.o_redir_pc); end
  endtask

  task automatic test_delayed_ack();
    bi.i_ex_valid = 1'b1; bi.i_br_en = 1'b1; bi.i_br_target = 32'h0000_2040;
    tick();
    bi.i_ex_valid = 1'b0; bi.i_br_en = 1'b0; bi.i_br_target = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      total++; if (bi.o_redir_req !== 1'b1 || bi.o_redir_pc !== 32'h0000_2040) begin bad++; $display("FAIL dly_req_c%0d: got req=%b pc=%h want 1 00002040", i, bi.o_redir_req, bi.o_redir_pc); end
      total++; if (bi.o_stall !== 1'b1 || bi.o_taken_cnt !== 32'd1) begin bad++; $display("FAIL dly_stall_c%0d: got stall=%b cnt=%0d want 1 1", i, bi.o_stall, bi.o_taken_cnt); end
      if (i == 6) bi.i_redir_ack = 1'b1;
      tick();
    end
    bi.i_redir_ack = 1'b0;
    total++; if (bi.o_redir_req !== 1'b0 || bi.o_flush !== 1'b1) begin bad++; $display("FAIL dly_flush1: got req=%b flush=%b want 0 1", bi.o_redir_req, bi.o_flush); end
    total++; if (bi.o_taken_cnt !== 32'd2) begin bad++; $display("FAIL dly_cnt: got %0d want 2", bi.o_taken_cnt); end
    tick();
    total++; if (bi.o_flush !== 1'b1 || bi.o_stall !== 1'b1) begin bad++; $display("FAIL dly_flush2: got flush=%b stall=%b want 1 1", bi.o_flush, bi.o_stall); end
    tick();
    total++; if (bi.o_flush !== 1'b0 || bi.o_taken_cnt !== 32'd2) begin bad++; $display("FAIL dly_end: got flush=%b cnt=%0d want 0 2", bi.o_flush, bi.o_taken_cnt); end
  endtask

  task automatic test_misalign();
    bi.i_ex_valid = 1'b1; bi.i_br_en = 1'b1; bi.i_br_target = 32'h0000_1002;
    tick();
    bi.i_ex_valid = 1'b0; bi.i_br_en = 1'b0;
    total++; if (bi.o_misalign !== 1'b1) begin bad++; $display("FAIL mis_pulse: got %b want 1", bi.o_misalign); end
    total++; if (bi.o_misalign_addr !== 32'h0000_1002) begin bad++; $display("FAIL mis_addr: got %h want 00001002", bi.o_misalign_addr); end
    total++; if (bi.o_redir_req !== 1'b0 || bi.o_flush !== 1'b0 || bi.o_stall !== 1'b0) begin bad++; $display("FAIL mis_quiet: got req=%b flush=%b stall=%b want 0 0 0", bi.o_redir_req, bi.o_flush, bi.o_stall); end
    total++; if (bi.o_taken_cnt !== 32'd2) begin bad++; $display("FAIL mis_cnt: got %0d want 2", bi.o_taken_cnt); end
    tick();
    total++; if (bi.o_misalign !== 1'b0) begin bad++; $display("FAIL mis_one_cycle: got %b want 0", bi.o_misalign); end
    total++; if (bi.o_misalign_addr !== 32'h0000_1002) begin bad++; $display("FAIL mis_addr_hold: got %h want 00001002", bi.o_misalign_addr); end
    total++; if (bi.o_redir_req !== 1'b0) begin bad++; $display("FAIL mis_no_req: got %b want 0", bi.o_redir_req); end
  endtask

  task automatic test_back_to_back();
    bi.i_ex_valid = 1'b1; bi.i_br_en = 1'b1; bi.i_br_target = 32'h0000_3000;
    tick();
    bi.i_br_target = 32'h0000_2000;
    total++; if (bi.o_redir_req !== 1'b1 || bi.o_redir_pc !== 32'h0000_3000) begin bad++; $display("FAIL b2b_req1: got req=%b pc=%h want 1 00003000", bi.o_redir_req, bi.o_redir_pc); end
    tick();
    total++; if (bi.o_redir_req !== 1'b1 || bi.o_redir_pc !== 32'h0000_3000) begin bad++; $display("FAIL b2b_ignored_req: got req=%b pc=%h want 1 00003000", bi.o_redir_req, bi.o_redir_pc); end
    bi.i_redir_ack = 1'b1;
    tick();
    bi.i_redir_ack = 1'b0;
    total++; if (bi.o_redir_req !== 1'b0 || bi.o_flush !== 1'b1 || bi.o_taken_cnt !== 32'd3) begin bad++; $display("FAIL b2b_flush1: got req=%b flush=%b cnt=%0d want 0 1 3", bi.o_redir_req, bi.o_flush, bi.o_taken_cnt); end
    tick();
    total++; if (bi.o_redir_req !== 1'b0 || bi.o_flush !== 1'b1 || bi.o_redir_pc !== 32'h0000_3000) begin bad++; $display("FAIL b2b_flush2: got req=%b flush=%b pc=%h want 0 1 00003000", bi.o_redir_req, bi.o_flush, bi.o_redir_pc); end
    tick();
    total++; if (bi.o_redir_req !== 1'b0 || bi.o_flush !== 1'b0 || bi.o_redir_pc !== 32'h0000_3000) begin bad++; $display("FAIL b2b_idle: got req=%b flush=%b pc=%h want 0 0 00003000", bi.o_redir_req, bi.o_flush, bi.o_redir_pc); end
    bi.i_br_target = 32'h0000_4000;
    tick();
    bi.i_ex_valid = 1'b0; bi.i_br_en = 1'b0;
    total++; if (bi.o_redir_req !== 1'b1 || bi.o_redir_pc !== 32'h0000_4000) begin bad++; $display("FAIL b2b_req2: got req=%b pc=%h want 1 00004000", bi.o_redir_req, bi.o_redir_pc); end
    bi.i_redir_ack = 1'b1;
    tick();
    bi.i_redir_ack = 1'b0;
    total++; if (bi.o_taken_cnt !== 32'd4 || bi.o_flush !== 1'b1) begin bad++; $display("FAIL b2b_cnt: got cnt=%0d flush=%b want 4 1", bi.o_taken_cnt, bi.o_flush); end
    tick();
    tick();
    total++; if (bi.o_flush !== 1'b0 || bi.o_stall !== 1'b0) begin bad++; $display("FAIL b2b_end: got flush=%b stall=%b want 0 0", bi.o_flush, bi.o_stall); end
  endtask

  task automatic test_reset_mid_req();
    bi.i_ex_valid = 1'b1; bi.i_br_en = 1'b1; bi.i_br_target = 32'h0000_5000;
    tick();
    bi.i_ex_valid = 1'b0; bi.i_br_en = 1'b0;
    total++; if (bi.o_redir_req !== 1'b1) begin bad++; $display("FAIL rmr_req: got %b want 1", bi.o_redir_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bi.o_redir_req !== 1'b0 || bi.o_flush !== 1'b0 || bi.o_stall !== 1'b0) begin bad++; $display("FAIL rmr_ctrl: got req=%b flush=%b stall=%b want 0 0 0", bi.o_redir_req, bi.o_flush, bi.o_stall); end
    total++; if (bi.o_redir_pc !== 32'h0 || bi.o_misalign_addr !== 32'h0 || bi.o_taken_cnt !== 32'h0) begin bad++; $display("FAIL rmr_data: got pc=%h maddr=%h cnt=%h want 0 0 0", bi.o_redir_pc, bi.o_misalign_addr, bi.o_taken_cnt); end
    bi.i_redir_ack = 1'b1;
    tick();
    tick();
    bi.i_redir_ack = 1'b0;
    total++; if (bi.o_taken_cnt !== 32'h0 || bi.o_flush !== 1'b0 || bi.o_redir_req !== 1'b0) begin bad++; $display("FAIL rmr_late_ack: got cnt=%0d flush=%b req=%b want 0 0 0", bi.o_taken_cnt, bi.o_flush, bi.o_redir_req); end
  endtask

  task automatic test_wrap_flush0();
    bi0.i_ex_valid = 1'b1; bi0.i_br_en = 1'b1; bi0.i_br_target = 32'h0000_0100;
    tick();
    bi0.i_ex_valid = 1'b0; bi0.i_br_en = 1'b0;
    total++; if (bi0.o_redir_req !== 1'b1 || bi0.o_flush !== 1'b1 || bi0.o_redir_pc !== 32'h0000_0100) begin bad++; $display("FAIL f0_req: got req=%b flush=%b pc=%h want 1 1 00000100", bi0.o_redir_req, bi0.o_flush, bi0.o_redir_pc); end
    bi0.i_redir_ack = 1'b1;
    tick();
    bi0.i_redir_ack = 1'b0;
    total++; if (bi0.o_redir_req !== 1'b0 || bi0.o_flush !== 1'b0 || bi0.o_stall !== 1'b0) begin bad++; $display("FAIL f0_drop: got req=%b flush=%b stall=%b want 0 0 0", bi0.o_redir_req, bi0.o_flush, bi0.o_stall); end
    total++; if (bi0.o_taken_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL f0_cnt_max: got %h want ffffffff", bi0.o_taken_cnt); end
    bi0.i_ex_valid = 1'b1; bi0.i_br_en = 1'b1; bi0.i_br_target = 32'h0000_0104;
    tick();
    bi0.i_ex_valid = 1'b0; bi0.i_br_en = 1'b0;
    total++; if (bi0.o_redir_req !== 1'b1 || bi0.o_redir_pc !== 32'h0000_0104) begin bad++; $display("FAIL f0_req2: got req=%b pc=%h want 1 00000104", bi0.o_redir_req, bi0.o_redir_pc); end
    bi0.i_redir_ack = 1'b1;
    tick();
    bi0.i_redir_ack = 1'b0;
    total++; if (bi0.o_taken_cnt !== 32'h0) begin bad++; $display("FAIL f0_wrap: got %h want 00000000", bi0.o_taken_cnt); end
    total++; if (bi0.o_flush !== 1'b0 || bi0.o_redir_req !== 1'b0) begin bad++; $display("FAIL f0_drop2: got flush=%b req=%b want 0 0", bi0.o_flush, bi0.o_redir_req); end
  endtask

  initial begin
    bi.i_ex_valid  = 1'b0; bi.i_br_en  = 1'b0; bi.i_br_target  = 32'h0; bi.i_redir_ack  = 1'b0;
    bi0.i_ex_valid = 1'b0; bi0.i_br_en = 1'b0; bi0.i_br_target = 32'h0; bi0.i_redir_ack = 1'b0;
    test_reset();
    test_immediate_ack();
    test_delayed_ack();
    test_misalign();
    test_back_to_back();
    test_reset_mid_req();
    test_wrap_flush0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencer between the EX-stage branch comparator and the front end. When the comparator reports a taken jump or branch for a valid EX instruction, this block issues a registered PC-redirect request to the fetch unit and holds it until the fetch unit acknowledges. It then kills younger IF/ID instructions for a programmable number of cycles, stalling the pipeline throughout. Misaligned targets are diverted to an exception pulse instead of a redirect, and every accepted redirect is counted.

## Interface
- FLUSH_CYCLES, 2, number of flush cycles after acknowledge; legal range 0..15.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ex_valid  in  1  EX stage holds a valid instruction this cycle.
- i_br_en  in  1  taken condition from the branch comparator; always true for JAL/JALR.
- i_br_target  in  32  computed target address for the EX instruction.
- o_redir_req  out  1  redirect request to the fetch unit.
- o_redir_pc  out  32  redirect address; valid while o_redir_req is high.
- i_redir_ack  in  1  fetch unit accepts the redirect when it is high together with o_redir_req.
- o_flush  out  1  kill instructions in IF/ID.
- o_stall  out  1  freeze the pipeline so no new instruction enters EX.
- o_misalign  out  1  one-cycle instruction-address-misaligned pulse.
- o_misalign_addr  out  32  offending target; holds its value until the next misalign event.
- o_taken_cnt  out  32  count of acknowledged redirects; wraps modulo 2^32.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the state is IDLE. A reset in any state aborts the sequence immediately, with no request or flush carried over.
- Trigger event is i_ex_valid & i_br_en, evaluated only in IDLE. Events in any other state are ignored; the pipeline is stalled, so none are expected.
- State IDLE:
  - Event with i_br_target[1:0] != 0: pulse o_misalign, latch the target into o_misalign_addr, and stay in IDLE. No redirect is issued and the counter is unchanged.
  - Event with an aligned target: latch the target into o_redir_pc and go to REQ.
- State REQ:
  - o_redir_req, o_flush and o_stall are all 1. o_redir_pc is stable.
  - Stays in REQ indefinitely until i_redir_ack.
  - On ack: increment o_taken_cnt, load the flush counter with FLUSH_CYCLES, then go to FLUSH, or to IDLE if FLUSH_CYCLES = 0.
- State FLUSH:
  - o_redir_req is 0; o_flush and o_stall are 1.
  - The flush counter decrements each cycle. When it reaches 0, go to IDLE.
- i_redir_ack while o_redir_req is low is ignored.
- o_redir_pc keeps its last value after the request drops. Only o_redir_req qualifies it.
- The flush counter is 4 bits wide. o_taken_cnt rolls over from 0xFFFFFFFF to 0 without any flag.

## Timing
- Event sampled at edge N:
  - REQ path: o_redir_req, o_flush and o_stall go high in cycle N+1.
  - Misalign path: o_misalign is high for cycle N+1 only.
- Ack sampled at edge M, where M ≥ N+1 and the earliest ack is in the first REQ cycle:
  - o_redir_req is low from M+1.
  - o_taken_cnt shows the incremented value from M+1.
  - o_flush and o_stall stay high through cycle M+FLUSH_CYCLES and drop at M+FLUSH_CYCLES+1.
- Redirect latency:
  - Minimum from event to request drop is 2 edges.
  - Total stall is (M−N) + FLUSH_CYCLES cycles.
- The first cycle back in IDLE can accept a new event; back-to-back redirects have no bubble beyond the FLUSH window.
- Reset asserted at any edge: all outputs are 0 in the following cycle.

## Test plan
- Aligned branch, immediate ack: target 0x0000_1000 with ack in the first REQ cycle, FLUSH_CYCLES=2.
  - req is high for 1 cycle, flush/stall are high for 3 cycles, pc = 0x1000, count = 1.
- Delayed ack: ack held off 5 cycles.
  - req and pc are stable for 6 cycles, then 2 flush cycles; no second count increment.
- Misaligned target 0x0000_1002:
  - o_misalign pulses for 1 cycle, o_misalign_addr = 0x1002, req/flush/stall stay 0, count is unchanged.
- Event while in REQ/FLUSH with a second target 0x2000, then back-to-back events:
  - The second event is ignored and pc stays at the first target.
  - An event in the first IDLE cycle after flush produces req on the next cycle.
- Reset and wrap:
  - i_rst pulsed mid-REQ: all outputs are 0 the next cycle, state is IDLE, and a later ack is ignored.
  - Counter preloaded near 0xFFFFFFFF: it wraps to 0 after the acknowledgements.
  - FLUSH_CYCLES=0: flush drops the cycle after ack.
